// File: rtl/led_blink_sequencer.sv
// led_blink_sequencer: steps led_blinker through rate codes with dwell/gap timing, plus manual pass-through.
// Optional SEQ_LOOP_EN: wrap to step 0 after the last gap instead of returning to idle.
module led_blink_sequencer #(
  parameter int DWELL_CYCLES = 100000,
  parameter int PAUSE_CYCLES = 1000,
  parameter int NUM_STEPS    = 4
) (
  input  logic       i_clock,
  input  logic       i_reset,
  input  logic       i_start,
  input  logic       i_stop,
  input  logic       i_manual,
  input  logic [1:0] i_man_sel,
  output logic       o_enable,
  output logic       o_switch_1,
  output logic       o_switch_2,
  output logic [1:0] o_step,
  output logic       o_busy,
  output logic       o_done
);
  localparam int MAXC = DWELL_CYCLES > PAUSE_CYCLES ? DWELL_CYCLES : PAUSE_CYCLES;
  localparam int CW = $clog2(MAXC) + 1;
  typedef enum logic [1:0] {IDLE, RUN, GAP} state_t;
  state_t state;
  logic [CW-1:0] cnt;
  logic [1:0] sw;
  logic dwell_end, gap_end, step_end, last_step;
  assign dwell_end = cnt == CW'(DWELL_CYCLES - 1);
  assign gap_end = cnt == CW'(PAUSE_CYCLES - 1);
  // with no pause the dwell end doubles as the step end
  assign step_end = state == RUN ? dwell_end && PAUSE_CYCLES == 0 : state == GAP && gap_end;
  assign last_step = o_step == 2'(NUM_STEPS - 1);
  assign o_switch_1 = sw[1];
  assign o_switch_2 = sw[0];
  always_ff @(posedge i_clock or posedge i_reset)
    if (i_reset) begin
      state <= IDLE;
      cnt <= '0;
      sw <= 2'b00;
      o_step <= 2'd0;
      o_enable <= 1'b0;
      o_busy <= 1'b0;
      o_done <= 1'b0;
    end else begin
      o_done <= 1'b0;
      if (i_stop) begin
        state <= IDLE;
        cnt <= '0;
        sw <= 2'b00;
        o_step <= 2'd0;
        o_enable <= 1'b0;
        o_busy <= 1'b0;
      end else if (state == IDLE) begin
        if (i_start && !i_manual) begin
          state <= RUN;
          cnt <= '0;
          sw <= 2'b00;
          o_step <= 2'd0;
          o_enable <= 1'b1;
          o_busy <= 1'b1;
        end else begin
          o_enable <= i_manual;
          sw <= i_manual ? i_man_sel : 2'b00;
        end
      end else if (step_end) begin
        cnt <= '0;
        if (!last_step) begin
          state <= RUN;
          o_step <= o_step + 2'd1;
          sw <= o_step + 2'd1;
          o_enable <= 1'b1;
        end else begin
          o_done <= 1'b1;
          o_step <= 2'd0;
          sw <= 2'b00;
`ifdef SEQ_LOOP_EN
          state <= RUN;
          o_enable <= 1'b1;
`else
          state <= IDLE;
          o_enable <= 1'b0;
          o_busy <= 1'b0;
`endif
        end
      end else if (state == RUN && dwell_end) begin
        state <= GAP;
        cnt <= '0;
        o_enable <= 1'b0;
      end else
        cnt <= cnt + CW'(1);
    end
endmodule

// File: tb/tb_led_blink_sequencer.sv
// tb_led_blink_sequencer: directed and random stimulus against an arithmetic timeline model.
module tb_led_blink_sequencer;
  localparam int D = 10, P = 2, N = 4, L = N * (D + P);
  logic clk = 0, rst = 1, start = 0, stop = 0, manual = 0;
  logic [1:0] sel = 2'b00;
  logic en, s1, s2, busy, done;
  logic [1:0] step;
  led_blink_sequencer #(.DWELL_CYCLES(D), .PAUSE_CYCLES(P), .NUM_STEPS(N)) u_dut (
    .i_clock(clk), .i_reset(rst), .i_start(start), .i_stop(stop), .i_manual(manual),
    .i_man_sel(sel), .o_enable(en), .o_switch_1(s1), .o_switch_2(s2), .o_step(step),
    .o_busy(busy), .o_done(done)
  );
  always #5 clk = ~clk;
  int checks = 0, failures = 0, k = 0;
  bit running = 0, rman = 0;
  logic [6:0] exp_v = '0;
  // {enable, sw1, sw2, step, busy, done} at cycle kk of a sequence
  function automatic logic [6:0] run_out(int kk);
    int st, r;
    logic [1:0] c;
    st = kk / (D + P);
    r = kk % (D + P);
    c = 2'(st);
    return {r < D, c, c, 1'b1, 1'b0};
  endfunction
  task automatic check(input string tag);
    checks++;
    assert ({en, s1, s2, step, busy, done} === exp_v)
    else begin
      failures++;
      $error("FAIL %s got=%b expected=%b", tag, {en, s1, s2, step, busy, done}, exp_v);
    end
  endtask
  task automatic tick(input bit st, input bit sp, input bit mn, input logic [1:0] sl, input string tag);
    start = st; stop = sp; manual = mn; sel = sl;
    @(posedge clk);
    if (sp) begin
      running = 0;
      exp_v = '0;
    end else if (!running) begin
      if (st && !mn) begin
        running = 1;
        k = 0;
        exp_v = run_out(0);
      end else
        exp_v = {mn, mn ? sl : 2'b00, 4'b0000};
    end else begin
      k++;
      if (k == L) begin
`ifdef SEQ_LOOP_EN
        k = 0;
        exp_v = run_out(0) | 7'b1;
`else
        running = 0;
        exp_v = 7'b1;
`endif
      end else
        exp_v = run_out(k);
    end
    #1 check(tag);
    start = 0; stop = 0;
  endtask
  initial begin
    #2 check("reset");
    repeat (2) @(posedge clk);
    #1 rst = 0;
    check("reset_release");
    tick(1, 0, 0, 2'b00, "t1_start");
    repeat (L) tick(0, 0, 0, 2'b00, "t1_seq");
    tick(0, 0, 0, 2'b00, "t1_idle");
    tick(1, 0, 0, 2'b00, "t2_start");
    repeat (2 * (D + P) + 3) tick(0, 0, 0, 2'b00, "t2_run");
    tick(0, 1, 0, 2'b00, "t2_stop");
    tick(0, 0, 0, 2'b00, "t2_idle");
    tick(1, 1, 0, 2'b00, "t3_start_stop");
    tick(0, 0, 0, 2'b00, "t3_idle");
    tick(0, 0, 1, 2'b10, "t4_manual");
    tick(1, 0, 1, 2'b10, "t4_start_ignored");
    tick(0, 0, 1, 2'b01, "t4_manual_sel");
    tick(0, 0, 0, 2'b10, "t4_off");
    tick(1, 0, 0, 2'b00, "t5_start");
    repeat (D + 1) tick(0, 0, 0, 2'b00, "t5_run");
    #2 rst = 1;
    #1 running = 0;
    exp_v = '0;
    check("t5_async_reset");
    #1 rst = 0;
    repeat (800) begin
      if ($urandom_range(0, 29) == 0) rman = ~rman;
      tick($urandom_range(0, 19) == 0, $urandom_range(0, 79) == 0, rman, 2'($urandom_range(0, 3)), "rand");
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
